// File: rtl/lab3_pkg.sv
// Shared types and constants for the lab3 sweep/capture stage.
package lab3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int          N_PATTERNS  = 16;
  localparam int          IDX_W       = 4;
  localparam int          SETTLE_W    = 4;
  localparam logic [15:0] LAB3A_TABLE = 16'h2812;

endpackage

// File: rtl/lab3_settle_timer.sv
// Loadable down-counter that tells the sweep FSM when a pattern has settled.
module lab3_settle_timer
  import lab3_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                load,
  input  logic                en,
  input  logic [SETTLE_W-1:0] load_val,
  output logic                zero
);

  logic [SETTLE_W-1:0] count_r;

  // Clear beats load beats decrement; the count parks at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {SETTLE_W{1'b0}};
    end else if (clear) begin
      count_r <= {SETTLE_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != {SETTLE_W{1'b0}})) begin
      count_r <= count_r - {{(SETTLE_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {SETTLE_W{1'b0}});

endmodule

// File: rtl/lab3_sweep_capture.sv
// Drives all 16 {w,x,y,z} patterns into a 4-input function block and
// captures its output into a truth table with a start/busy/done handshake.
module lab3_sweep_capture
  import lab3_pkg::*;
#(
  parameter int          SETTLE_CYCLES  = 1,
  parameter logic [15:0] EXPECTED_TABLE = LAB3A_TABLE
) (
  input  logic        CL2947MP_clk,
  input  logic        CL2947MP_rst_n,
  input  logic        CL2947MP_start,
  input  logic        CL2947MP_abort,
  output logic        CL2947MP_w,
  output logic        CL2947MP_x,
  output logic        CL2947MP_y,
  output logic        CL2947MP_z,
  input  logic        CL2947MP_outa,
  output logic        CL2947MP_busy,
  output logic        CL2947MP_done,
  output logic [15:0] CL2947MP_table,
  output logic [4:0]  CL2947MP_ones,
  output logic        CL2947MP_valid,
  output logic        CL2947MP_match
);

  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
    $error("lab3_sweep_capture: SETTLE_CYCLES must be in 1..15");
  end

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0]    LAST_INDEX  = IDX_W'(N_PATTERNS - 1);

  state_t           state_r;
  logic [IDX_W-1:0] index_r;
  logic [IDX_W-1:0] pat_r;
  logic             busy_r;
  logic             done_r;
  logic             valid_r;
  logic [15:0]      truth_r;
  logic [4:0]       ones_r;

  logic tmr_load_s;
  logic tmr_en_s;
  logic tmr_clear_s;
  logic tmr_zero_s;

  // Timer control decoded from the current state; abort also flushes the timer.
  always_comb begin
    tmr_load_s  = 1'b0;
    tmr_en_s    = 1'b0;
    tmr_clear_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tmr_load_s = CL2947MP_start && !CL2947MP_abort;
      end
      ST_DRIVE: begin
        tmr_en_s    = !CL2947MP_abort;
        tmr_clear_s = CL2947MP_abort;
      end
      ST_SAMPLE: begin
        tmr_load_s  = !CL2947MP_abort && (index_r != LAST_INDEX);
        tmr_clear_s = CL2947MP_abort;
      end
      default: begin
        tmr_load_s  = 1'b0;
        tmr_en_s    = 1'b0;
        tmr_clear_s = 1'b0;
      end
    endcase
  end

  lab3_settle_timer u_timer (
    .clk      (CL2947MP_clk),
    .rst_n    (CL2947MP_rst_n),
    .clear    (tmr_clear_s),
    .load     (tmr_load_s),
    .en       (tmr_en_s),
    .load_val (SETTLE_LOAD),
    .zero     (tmr_zero_s)
  );

  // Sweep FSM with registered pattern, handshake and capture outputs.
  always_ff @(posedge CL2947MP_clk) begin
    if (!CL2947MP_rst_n) begin
      state_r <= ST_IDLE;
      index_r <= {IDX_W{1'b0}};
      pat_r   <= {IDX_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
      truth_r <= 16'h0000;
      ones_r  <= 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (CL2947MP_start && !CL2947MP_abort) begin
            state_r <= ST_DRIVE;
            index_r <= {IDX_W{1'b0}};
            pat_r   <= {IDX_W{1'b0}};
            busy_r  <= 1'b1;
            valid_r <= 1'b0;
            truth_r <= 16'h0000;
            ones_r  <= 5'd0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DRIVE: begin
          if (CL2947MP_abort) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            pat_r   <= {IDX_W{1'b0}};
          end else if (tmr_zero_s) begin
            state_r <= ST_SAMPLE;
          end else begin
            state_r <= ST_DRIVE;
          end
        end
        ST_SAMPLE: begin
          // An abort here drops the sample: the partial table stops at index-1.
          if (CL2947MP_abort) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            pat_r   <= {IDX_W{1'b0}};
          end else begin
            truth_r[index_r] <= CL2947MP_outa;
            ones_r           <= ones_r + {4'd0, CL2947MP_outa};
            if (index_r == LAST_INDEX) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              pat_r   <= {IDX_W{1'b0}};
            end else begin
              state_r <= ST_DRIVE;
              index_r <= index_r + {{(IDX_W-1){1'b0}}, 1'b1};
              pat_r   <= index_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          valid_r <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          pat_r   <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

  assign CL2947MP_w     = pat_r[3];
  assign CL2947MP_x     = pat_r[2];
  assign CL2947MP_y     = pat_r[1];
  assign CL2947MP_z     = pat_r[0];
  assign CL2947MP_busy  = busy_r;
  assign CL2947MP_done  = done_r;
  assign CL2947MP_table = truth_r;
  assign CL2947MP_ones  = ones_r;
  assign CL2947MP_valid = valid_r;
  assign CL2947MP_match = valid_r && (truth_r == EXPECTED_TABLE);

endmodule

// File: tb/tb_lab3_sweep_capture.sv
// Bench: two instances (settle 1 and 3) driving a table-lookup function model.
module tb_lab3_sweep_capture;

  localparam logic [15:0] GOLDEN = 16'h2812;

  logic        clk;
  logic        rst_n [2];
  logic        start [2];
  logic        abort [2];
  logic        outa  [2];
  logic        w [2], x [2], y [2], z [2];
  logic        busy [2], done [2], valid [2], match [2];
  logic [15:0] tbl  [2];
  logic [4:0]  ones [2];
  logic [15:0] ftab [2];

  int tests  = 0;
  int failed = 0;

  // Function block model: outa is the truth-table bit selected by {w,x,y,z}.
  assign outa[0] = ftab[0][{w[0], x[0], y[0], z[0]}];
  assign outa[1] = ftab[1][{w[1], x[1], y[1], z[1]}];

  lab3_sweep_capture #(.SETTLE_CYCLES(1), .EXPECTED_TABLE(GOLDEN)) u_s1 (
    .CL2947MP_clk(clk), .CL2947MP_rst_n(rst_n[0]), .CL2947MP_start(start[0]),
    .CL2947MP_abort(abort[0]), .CL2947MP_w(w[0]), .CL2947MP_x(x[0]),
    .CL2947MP_y(y[0]), .CL2947MP_z(z[0]), .CL2947MP_outa(outa[0]),
    .CL2947MP_busy(busy[0]), .CL2947MP_done(done[0]), .CL2947MP_table(tbl[0]),
    .CL2947MP_ones(ones[0]), .CL2947MP_valid(valid[0]), .CL2947MP_match(match[0]));

  lab3_sweep_capture #(.SETTLE_CYCLES(3), .EXPECTED_TABLE(GOLDEN)) u_s3 (
    .CL2947MP_clk(clk), .CL2947MP_rst_n(rst_n[1]), .CL2947MP_start(start[1]),
    .CL2947MP_abort(abort[1]), .CL2947MP_w(w[1]), .CL2947MP_x(x[1]),
    .CL2947MP_y(y[1]), .CL2947MP_z(z[1]), .CL2947MP_outa(outa[1]),
    .CL2947MP_busy(busy[1]), .CL2947MP_done(done[1]), .CL2947MP_table(tbl[1]),
    .CL2947MP_ones(ones[1]), .CL2947MP_valid(valid[1]), .CL2947MP_match(match[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] pat(input int d);
    return {w[d], x[d], y[d], z[d]};
  endfunction

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Full sweep; start is re-asserted at edge restart_at (if >0) and must be ignored.
  task automatic run_sweep(input int d, input int restart_at);
    int s    = settle_of(d);
    int last = 16 * (s + 1);
    start[d] = 1'b1;
    step();
    start[d] = 1'b0;
    chk("busy_rise", 32'(busy[d]), 32'd1);
    chk("pat_first", 32'(pat(d)), 32'd0);
    for (int n = 1; n <= last; n++) begin
      if (n == restart_at) start[d] = 1'b1;
      step();
      start[d] = 1'b0;
      chk("done_timing", 32'(done[d]), (n == last) ? 32'd1 : 32'd0);
      chk("busy_timing", 32'(busy[d]), (n < last) ? 32'd1 : 32'd0);
      if (n < last) chk("pattern_step", 32'(pat(d)), 32'(n / (s + 1)));
    end
    chk("table_at_done", 32'(tbl[d]), 32'(ftab[d]));
    chk("ones_at_done", 32'(ones[d]), 32'($countones(ftab[d])));
    step();
    chk("done_pulse_end", 32'(done[d]), 32'd0);
    chk("valid_after", 32'(valid[d]), 32'd1);
    chk("match_after", 32'(match[d]), (ftab[d] == GOLDEN) ? 32'd1 : 32'd0);
    chk("table_held", 32'(tbl[d]), 32'(ftab[d]));
    chk("idle_pattern", 32'(pat(d)), 32'd0);
  endtask

  // Abort after edge n_ab from start; patterns before the current one stay captured.
  task automatic run_abort(input int d, input int n_ab);
    int s = settle_of(d);
    int p = n_ab / (s + 1);
    logic [15:0] exp_tab;
    exp_tab = ftab[d] & 16'((32'd1 << p) - 32'd1);
    start[d] = 1'b1;
    step();
    start[d] = 1'b0;
    for (int n = 1; n <= n_ab; n++) step();
    abort[d] = 1'b1;
    step();
    abort[d] = 1'b0;
    chk("abort_busy", 32'(busy[d]), 32'd0);
    chk("abort_pattern", 32'(pat(d)), 32'd0);
    chk("abort_valid", 32'(valid[d]), 32'd0);
    chk("abort_match", 32'(match[d]), 32'd0);
    chk("abort_table", 32'(tbl[d]), 32'(exp_tab));
    chk("abort_ones", 32'(ones[d]), 32'($countones(exp_tab)));
    for (int n = 0; n < 2 * (s + 1); n++) begin
      step();
      chk("abort_no_done", 32'(done[d]), 32'd0);
    end
  endtask

  task automatic check_all_zero(input int d);
    chk("rst_busy", 32'(busy[d]), 32'd0);
    chk("rst_done", 32'(done[d]), 32'd0);
    chk("rst_valid", 32'(valid[d]), 32'd0);
    chk("rst_match", 32'(match[d]), 32'd0);
    chk("rst_table", 32'(tbl[d]), 32'd0);
    chk("rst_ones", 32'(ones[d]), 32'd0);
    chk("rst_pattern", 32'(pat(d)), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      start[d] = 1'b0;
      abort[d] = 1'b0;
      ftab[d]  = GOLDEN;
    end
    step();
    step();
    check_all_zero(0);
    check_all_zero(1);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    step();

    // Golden sweep, then stuck-at outputs.
    run_sweep(0, 0);
    ftab[0] = 16'hFFFF;
    run_sweep(0, 0);
    ftab[0] = 16'h0000;
    run_sweep(0, 0);

    // Random function tables.
    for (int i = 0; i < 4; i++) begin
      ftab[0] = 16'($urandom);
      run_sweep(0, 0);
    end

    // Longer settle time; pattern 11 reads 1 on the golden function.
    ftab[1] = GOLDEN;
    run_sweep(1, 0);
    chk("pattern11_bit", 32'(tbl[1][11]), 32'd1);

    // Abort during pattern 5 (DRIVE phase), then random abort points.
    ftab[0] = GOLDEN;
    run_abort(0, 10);
    chk("abort5_table", 32'(tbl[0]), 32'h0012);
    for (int i = 0; i < 4; i++) begin
      ftab[1] = 16'($urandom);
      run_abort(1, int'($urandom_range(0, 63)));
    end

    // Start mid-sweep is ignored; then start+abort together in IDLE.
    ftab[0] = GOLDEN;
    run_sweep(0, 7);
    start[0] = 1'b1;
    abort[0] = 1'b1;
    step();
    chk("start_abort_busy", 32'(busy[0]), 32'd0);
    step();
    start[0] = 1'b0;
    abort[0] = 1'b0;
    chk("start_abort_busy2", 32'(busy[0]), 32'd0);
    chk("start_abort_valid", 32'(valid[0]), 32'd1);
    chk("start_abort_table", 32'(tbl[0]), 32'(GOLDEN));
    step();
    chk("start_abort_idle", 32'(busy[0]), 32'd0);

    // Reset during pattern 9, then a clean sweep.
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    for (int n = 1; n <= 18; n++) step();
    chk("pre_reset_pattern", 32'(pat(0)), 32'd9);
    rst_n[0] = 1'b0;
    step();
    rst_n[0] = 1'b1;
    check_all_zero(0);
    step();
    run_sweep(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/lab3_sweep_capture.md
Name: lab3_sweep_capture

Overview:
- Sequential stimulus/capture stage wrapped around the 4-input combinational function block (inputs w,x,y,z; output outa).
- Upstream role: on a start request, it drives all 16 input patterns {w,x,y,z} = 0..15 onto the function block, with w as the MSB.
- Downstream role: after a programmable settle time per pattern, it samples outa and builds a 16-bit truth table.
- At the end of the sweep it reports the ones count and a pass/fail against the expected table, using a start/busy/done handshake.

Parameters:
- SETTLE_CYCLES, 1, cycles each pattern is held before sampling. Legal range 1..15; values outside this range are a synthesis-time error.
- EXPECTED_TABLE, 16'h2812, golden truth table. Bit i is the expected outa for pattern i. 0x2812 means outa=1 at patterns 1, 4, 11, 13.

Ports:
- CL2947MP_clk  in  1  single clock, rising edge.
- CL2947MP_rst_n  in  1  synchronous, active-low reset.
- CL2947MP_start  in  1  sweep request, sampled in IDLE only.
- CL2947MP_abort  in  1  cancels a sweep in progress.
- CL2947MP_w  out  1  function input, bit 3 of the pattern.
- CL2947MP_x  out  1  function input, bit 2 of the pattern.
- CL2947MP_y  out  1  function input, bit 1 of the pattern.
- CL2947MP_z  out  1  function input, bit 0 of the pattern.
- CL2947MP_outa  in  1  function output being characterised.
- CL2947MP_busy  out  1  high in the DRIVE and SAMPLE states.
- CL2947MP_done  out  1  one-cycle pulse when a sweep completes.
- CL2947MP_table  out  16  captured truth table; bit i is outa at pattern i.
- CL2947MP_ones  out  5  popcount of the table, range 0..16.
- CL2947MP_valid  out  1  table is complete and current.
- CL2947MP_match  out  1  valid && (table == EXPECTED_TABLE).

Behaviour:
- Reset: when rst_n=0 at a clock edge, the following clear on that edge:
  - state goes to IDLE;
  - w, x, y, z, busy, done, valid and match go to 0;
  - table goes to 16'h0 and ones to 5'd0;
  - the pattern index and settle counter go to 0.
- Reset mid-sweep: same result; the partial table is discarded.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - w,x,y,z are held at 0.
  - start=1 and abort=0 moves to DRIVE and, on the same edge:
    - index goes to 0;
    - table, ones and valid clear;
    - settle counter loads SETTLE_CYCLES-1.
- DRIVE:
  - {w,x,y,z} = index, driven from registers (glitch-free).
  - The state is held for SETTLE_CYCLES cycles: the counter decrements and the FSM moves to SAMPLE when the counter reaches 0.
- SAMPLE (one cycle):
  - Writes table[index] <= outa; ones increments by outa.
  - If index==15, go to DONE.
  - Otherwise index++, reload the settle counter, and return to DRIVE.
  - Inputs stay at the current index for the whole SAMPLE cycle.
- DONE (one cycle): done=1 and valid<=1, then go to IDLE.
- Timing:
  - Each pattern takes SETTLE_CYCLES+1 cycles.
  - With the edge that accepts start counted as edge 0, the FSM enters DONE after edge 16*(SETTLE_CYCLES+1), so done is high in the cycle that follows that edge.
- Output registers: table, ones and valid hold their values in IDLE until the next accepted start or a reset.
- match is combinational from valid and table; it is 0 whenever valid=0.
- start while busy: ignored; no restart, no effect.
- abort:
  - In DRIVE or SAMPLE, goes to IDLE on the next edge. Outputs return to 0, valid stays 0, done does not pulse, and the partial table stays visible.
  - In DONE, ignored: the sweep completes.
- start and abort in the same IDLE cycle: abort wins and the FSM stays in IDLE.
- Index arithmetic: 4-bit, no wrap is ever used because the FSM exits at index 15.
- Ones counter: 5 bits so that 16 fits without overflow.

Decomposition:
- Shared package lab3_pkg:
  - state enum (IDLE, DRIVE, SAMPLE, DONE);
  - N_PATTERNS = 16;
  - LAB3A_TABLE = 16'h2812, the default for EXPECTED_TABLE;
  - the index width (4).
- Sub-module lab3_settle_timer: a loadable down-counter with a zero flag, driven by a load/enable pair from the FSM.
- The function block is not instantiated here; the top level connects w/x/y/z/outa.

Test Plan:
1. Reset, then SETTLE_CYCLES=1, with the function block connected. Pulse start for one cycle.
   - busy rises on the next edge.
   - done is high exactly in the cycle after edge 32 from start.
   - table=16'h2812, ones=4, valid=1, match=1.
2. Same sweep with outa stuck at 1.
   - table=16'hFFFF, ones=16, match=0.
   - Then with outa stuck at 0: table=16'h0000, ones=0, match=0.
3. SETTLE_CYCLES=3. Check cycle by cycle:
   - {w,x,y,z} steps 0→15, each value held for 4 cycles;
   - done arrives in the cycle after edge 64;
   - pattern 11 (1011) reads outa=1.
4. Start a sweep and assert abort during pattern 5.
   - IDLE on the next edge, w,x,y,z=0, no done pulse, valid=0.
   - table bits 1 and 4 are set and all higher bits are 0.
5. Assert start again mid-sweep and check it is ignored (no index reset). Then in IDLE assert start and abort together: the FSM stays in IDLE and busy stays 0.
6. Drive rst_n=0 for one cycle during pattern 9.
   - All outputs are 0 on the next edge.
   - A new start then completes normally with table=16'h2812.
